// File: rtl/raster_to_blocks_if.sv
// Stream bundle for raster_to_blocks: HDMI raster beats in, 8x8 block beats out.
interface raster_to_blocks_if #(
    parameter int N     = 2,
    parameter int CH    = 3,
    parameter int DW    = 8,
    parameter int X_RES = 2160,
    parameter int Y_RES = 1200,
    parameter int BLK   = 8
);
    localparam int W  = N * CH * DW;
    localparam int XW = (X_RES / BLK > 1) ? $clog2(X_RES / BLK) : 1;
    localparam int YW = (Y_RES / BLK > 1) ? $clog2(Y_RES / BLK) : 1;

    logic          hdmi_v_sync;
    logic          hdmi_data_valid;
    logic [W-1:0]  hdmi_data;

    // A block beat transfers on a rising edge with blk_valid && blk_ready; once valid is
    // raised, data and flags stay put until that transfer, and valid never depends on ready.
    logic          blk_valid;
    logic          blk_ready;
    logic [W-1:0]  blk_data;
    logic          blk_sob;
    logic          blk_eob;
    logic          blk_sof;
    logic          blk_eof;
    logic [XW-1:0] blk_x;
    logic [YW-1:0] blk_y;

    modport master (
        output hdmi_v_sync, hdmi_data_valid, hdmi_data, blk_ready,
        input  blk_valid, blk_data, blk_sob, blk_eob, blk_sof, blk_eof, blk_x, blk_y
    );
    modport slave (
        input  hdmi_v_sync, hdmi_data_valid, hdmi_data, blk_ready,
        output blk_valid, blk_data, blk_sob, blk_eob, blk_sof, blk_eof, blk_x, blk_y
    );
endinterface

// File: rtl/raster_to_blocks.sv
// Raster-to-block converter: ping-pong stripe banks written in raster order, read out
// block by block through a 4-entry output FIFO with ready/valid backpressure.
module raster_to_blocks #(
    parameter int N     = 2,
    parameter int CH    = 3,
    parameter int DW    = 8,
    parameter int X_RES = 2160,
    parameter int Y_RES = 1200,
    parameter int BLK   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       err_clr,
    output logic       err_ovf,
    output logic       err_short,
    output logic [1:0] read_state,
    raster_to_blocks_if.slave bus
);
    localparam int W  = N * CH * DW;
    localparam int D  = BLK * X_RES / N;
    localparam int AW = $clog2(D);
    localparam int EB = BLK / N;
    localparam int EW = (EB > 1) ? $clog2(EB) : 1;
    localparam int LW = $clog2(BLK);
    localparam int XB = X_RES / BLK;
    localparam int YB = Y_RES / BLK;
    localparam int XW = (XB > 1) ? $clog2(XB) : 1;
    localparam int YW = (YB > 1) ? $clog2(YB) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} rd_state_t;
    typedef struct packed {
        logic [W-1:0]  data;
        logic          sob;
        logic          eob;
        logic          sof;
        logic          eof;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
    } beat_t;

    logic [W-1:0] mem [2][D];

    logic          v_sync_q, cap_en, wr_sel, wr_wrapped;
    logic [AW-1:0] wr_addr;
    logic [YW-1:0] wr_row;
    logic          frame_start, do_wr, wr_last, rd_busy, handoff, overflow;

    rd_state_t     rd_state, rd_state_nx;
    logic          rd_sel, rd_first, issue, load, load_pend, last_issue, is_sob, is_eob;
    logic [YW-1:0] rd_row;
    logic [EW-1:0] elem;
    logic [LW-1:0] line;
    logic [XW-1:0] blk;
    logic [AW-1:0] rd_addr;
    logic          pend_vld, pend_sel, pend_first;
    logic [YW-1:0] pend_row;

    logic          rd_vld, rd_sob, rd_eob, rd_sof, rd_eof;
    logic [XW-1:0] rd_x;
    logic [YW-1:0] rd_y;
    logic [W-1:0]  rd_q;

    beat_t         fifo [4];
    logic [1:0]    wp, rp;
    logic [2:0]    cnt;
    logic          push, pop;

    assign frame_start = v_sync_q & ~bus.hdmi_v_sync;
    assign do_wr       = bus.hdmi_data_valid & cap_en & ~frame_start;
    assign wr_last     = (wr_addr == AW'(D - 1));
    // A stripe may still be handed over while the previous one only drains the FIFO.
    assign rd_busy     = (rd_state == RUN) | pend_vld;
    assign handoff     = do_wr & wr_last & ~rd_busy;
    assign overflow    = do_wr & wr_last & rd_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_sync_q   <= 1'b0;
            cap_en     <= 1'b0;
            wr_sel     <= 1'b0;
            wr_wrapped <= 1'b0;
            wr_addr    <= '0;
            wr_row     <= '0;
            err_ovf    <= 1'b0;
            err_short  <= 1'b0;
        end else begin
            v_sync_q <= bus.hdmi_v_sync;
            if (frame_start) begin
                cap_en     <= en;
                wr_addr    <= '0;
                wr_row     <= '0;
                wr_sel     <= 1'b0;
                wr_wrapped <= 1'b0;
            end else if (do_wr) begin
                wr_addr <= wr_last ? '0 : wr_addr + 1'b1;
                if (overflow) cap_en <= 1'b0;
                if (handoff) begin
                    wr_sel <= ~wr_sel;
                    if (wr_row == YW'(YB - 1)) begin
                        wr_row     <= '0;
                        wr_wrapped <= 1'b1;
                    end else begin
                        wr_row <= wr_row + 1'b1;
                    end
                end
            end
            if (frame_start && wr_addr != '0) err_short <= 1'b1;
            else if (err_clr)                 err_short <= 1'b0;
            if (overflow)     err_ovf <= 1'b1;
            else if (err_clr) err_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_sel][wr_addr] <= bus.hdmi_data;
        rd_q <= mem[rd_sel][rd_addr];
    end

    assign rd_addr = AW'(int'(line) * (X_RES / N) + int'(blk) * EB + int'(elem));
    assign is_sob  = (elem == '0) && (line == '0);
    assign is_eob  = (elem == EW'(EB - 1)) && (line == LW'(BLK - 1));

    always_comb begin
        rd_state_nx = rd_state;
        issue       = 1'b0;
        load        = 1'b0;
        load_pend   = 1'b0;
        last_issue  = is_eob && (blk == XW'(XB - 1));
        case (rd_state)
            IDLE: if (handoff) begin
                load        = 1'b1;
                rd_state_nx = RUN;
            end
            RUN: begin
                issue = ({1'b0, cnt} + {3'b000, rd_vld}) < 4'd4;
                if (issue && last_issue) rd_state_nx = DRAIN;
            end
            DRAIN: if (cnt == 3'd0 && !rd_vld) begin
                if (pend_vld) begin
                    load        = 1'b1;
                    load_pend   = 1'b1;
                    rd_state_nx = RUN;
                end else if (handoff) begin
                    load        = 1'b1;
                    rd_state_nx = RUN;
                end else begin
                    rd_state_nx = IDLE;
                end
            end
            default: rd_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state   <= IDLE;
            rd_sel     <= 1'b0;
            rd_first   <= 1'b0;
            rd_row     <= '0;
            elem       <= '0;
            line       <= '0;
            blk        <= '0;
            pend_vld   <= 1'b0;
            pend_sel   <= 1'b0;
            pend_first <= 1'b0;
            pend_row   <= '0;
            rd_vld     <= 1'b0;
            rd_sob     <= 1'b0;
            rd_eob     <= 1'b0;
            rd_sof     <= 1'b0;
            rd_eof     <= 1'b0;
            rd_x       <= '0;
            rd_y       <= '0;
        end else begin
            rd_state <= rd_state_nx;
            rd_vld   <= issue;
            if (load) begin
                rd_sel   <= load_pend ? pend_sel : wr_sel;
                rd_row   <= load_pend ? pend_row : wr_row;
                rd_first <= load_pend ? pend_first : ~wr_wrapped;
                elem     <= '0;
                line     <= '0;
                blk      <= '0;
            end else if (issue) begin
                if (elem == EW'(EB - 1)) begin
                    elem <= '0;
                    if (line == LW'(BLK - 1)) begin
                        line <= '0;
                        blk  <= (blk == XW'(XB - 1)) ? '0 : blk + 1'b1;
                    end else begin
                        line <= line + 1'b1;
                    end
                end else begin
                    elem <= elem + 1'b1;
                end
            end
            if (handoff && !load) begin
                pend_vld   <= 1'b1;
                pend_sel   <= wr_sel;
                pend_row   <= wr_row;
                pend_first <= ~wr_wrapped;
            end else if (load_pend) begin
                pend_vld <= 1'b0;
            end
            if (issue) begin
                rd_sob <= is_sob;
                rd_eob <= is_eob;
                rd_sof <= is_sob && (blk == '0) && (rd_row == '0) && rd_first;
                rd_eof <= last_issue && (rd_row == YW'(YB - 1));
                rd_x   <= blk;
                rd_y   <= rd_row;
            end
        end
    end

    assign push = rd_vld;
    assign pop  = bus.blk_valid & bus.blk_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
            for (int i = 0; i < 4; i++) fifo[i] <= '0;
        end else begin
            if (push) begin
                fifo[wp] <= '{data: rd_q, sob: rd_sob, eob: rd_eob, sof: rd_sof,
                              eof: rd_eof, x: rd_x, y: rd_y};
                wp <= wp + 1'b1;
            end
            if (pop) rp <= rp + 1'b1;
            cnt <= cnt + {2'b00, push} - {2'b00, pop};
        end
    end

    assign bus.blk_valid = (cnt != 3'd0);
    assign bus.blk_data  = fifo[rp].data;
    assign bus.blk_sob   = fifo[rp].sob;
    assign bus.blk_eob   = fifo[rp].eob;
    assign bus.blk_sof   = fifo[rp].sof;
    assign bus.blk_eof   = fifo[rp].eof;
    assign bus.blk_x     = fifo[rp].x;
    assign bus.blk_y     = fifo[rp].y;
    assign read_state    = rd_state;
endmodule

// File: tb/tb_raster_to_blocks.sv
// Directed bench for raster_to_blocks on a 16x16 frame of ramp pixels (value = raster index).
module tb_raster_to_blocks;
    localparam int N = 2, CH = 3, DW = 8, X_RES = 16, Y_RES = 16, BLK = 8;
    localparam int W   = N * CH * DW;
    localparam int TW  = W + 6;
    localparam int GAP = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic err_clr = 1'b0;
    logic err_ovf, err_short;
    logic [1:0] read_state;

    raster_to_blocks_if #(.N(N), .CH(CH), .DW(DW), .X_RES(X_RES), .Y_RES(Y_RES), .BLK(BLK)) bus ();

    raster_to_blocks #(.N(N), .CH(CH), .DW(DW), .X_RES(X_RES), .Y_RES(Y_RES), .BLK(BLK)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .err_clr(err_clr), .err_ovf(err_ovf),
        .err_short(err_short), .read_state(read_state), .bus(bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int ready_mode = 1;
    int first_valid_cyc = 0;
    int last0_cyc = 0;
    logic [TW-1:0] exp_q[$];
    logic [TW-1:0] obs_q[$];
    logic hold_pend = 1'b0;
    logic [TW-1:0] held;

    task automatic chk(string tag, logic [TW-1:0] got, logic [TW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] pix_beat(int idx);
        logic [W-1:0] d = '0;
        for (int p = 0; p < N; p++)
            for (int c = 0; c < CH; c++)
                d[(p*CH+c)*DW +: DW] = 8'((idx + p) % 256);
        return d;
    endfunction

    function automatic logic [TW-1:0] exp_beat(int s, int b, int l, int e);
        int idx = (s * BLK + l) * X_RES + b * BLK + e * N;
        bit sob = (e == 0) && (l == 0);
        bit eob = (e == BLK / N - 1) && (l == BLK - 1);
        bit sof = sob && (b == 0) && (s == 0);
        bit eof = eob && (b == X_RES / BLK - 1) && (s == Y_RES / BLK - 1);
        return {sob, eob, sof, eof, 1'(b), 1'(s), pix_beat(idx)};
    endfunction

    function automatic logic [TW-1:0] obs_beat();
        return {bus.blk_sob, bus.blk_eob, bus.blk_sof, bus.blk_eof, bus.blk_x, bus.blk_y, bus.blk_data};
    endfunction

    task automatic expect_stripe(int s);
        for (int b = 0; b < X_RES / BLK; b++)
            for (int l = 0; l < BLK; l++)
                for (int e = 0; e < BLK / N; e++)
                    exp_q.push_back(exp_beat(s, b, l, e));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame_start();
        bus.hdmi_v_sync = 1'b1;
        repeat (3) tick();
        bus.hdmi_v_sync = 1'b0;
        repeat (3) tick();
    endtask

    // Beat k carries pixels 2k and 2k+1; a blanking gap follows every line.
    task automatic send_beats(int count);
        for (int k = 0; k < count; k++) begin
            bus.hdmi_data_valid = 1'b1;
            bus.hdmi_data = pix_beat(k * N);
            if (k == 63) last0_cyc = cyc;
            tick();
            if (k % (X_RES / N) == X_RES / N - 1) begin
                bus.hdmi_data_valid = 1'b0;
                repeat (GAP) tick();
            end
        end
        bus.hdmi_data_valid = 1'b0;
    endtask

    task automatic wait_obs();
        int i = 0;
        while (obs_q.size() < exp_q.size() && i < 4000) begin
            tick();
            i++;
        end
        repeat (20) tick();
    endtask

    task automatic cmp_all(string tag);
        chk({tag, "_count"}, TW'(obs_q.size()), TW'(exp_q.size()));
        while (obs_q.size() > 0 && exp_q.size() > 0)
            chk(tag, obs_q.pop_front(), exp_q.pop_front());
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    initial begin
        bus.blk_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.blk_ready = 1'b0;
                1:       bus.blk_ready = 1'b1;
                default: bus.blk_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                chk("stall_valid", TW'(bus.blk_valid), TW'(1));
                chk("stall_hold", obs_beat(), held);
            end
            if (bus.blk_valid && first_valid_cyc == -1) first_valid_cyc = cyc;
            if (bus.blk_valid && bus.blk_ready) obs_q.push_back(obs_beat());
            hold_pend = bus.blk_valid && !bus.blk_ready;
            held = obs_beat();
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        bus.hdmi_v_sync = 1'b0;
        bus.hdmi_data_valid = 1'b0;
        bus.hdmi_data = '0;
        repeat (3) tick();
        chk("rst_valid", TW'(bus.blk_valid), TW'(0));
        chk("rst_beat", obs_beat(), TW'(0));
        chk("rst_err", TW'({err_ovf, err_short}), TW'(0));
        chk("rst_state", TW'(read_state), TW'(0));
        rst_n = 1'b1;
        tick();

        // 1: ramp frame, ready high, latency and spot values
        en = 1'b1;
        ready_mode = 1;
        first_valid_cyc = -1;
        expect_stripe(0);
        expect_stripe(1);
        frame_start();
        send_beats(128);
        wait_obs();
        chk("t1_latency", TW'(first_valid_cyc - last0_cyc), TW'(3));
        chk("t1_b10_beat0_data", TW'(obs_q[32][W-1:0]), TW'(48'h090909080808));
        chk("t1_b10_beat0_x", TW'(obs_q[32][W+1]), TW'(1));
        chk("t1_sof_beat0", TW'(obs_q[0][W+3]), TW'(1));
        chk("t1_eof_beat127", TW'(obs_q[127][W+2]), TW'(1));
        chk("t1_eob_beat31", TW'(obs_q[31][W+4]), TW'(1));
        chk("t1_err", TW'({err_ovf, err_short}), TW'(0));
        cmp_all("t1");

        // 2: same frame under random backpressure
        ready_mode = 2;
        expect_stripe(0);
        expect_stripe(1);
        frame_start();
        send_beats(128);
        wait_obs();
        cmp_all("t2");
        ready_mode = 1;
        repeat (4) tick();

        // 3: ready held low across both stripes -> overflow, later beats dropped
        ready_mode = 0;
        expect_stripe(0);
        frame_start();
        send_beats(128);
        send_beats(64);
        chk("t3_ovf_set", TW'(err_ovf), TW'(1));
        chk("t3_short_clear", TW'(err_short), TW'(0));
        pulse_clr();
        chk("t3_ovf_cleared", TW'(err_ovf), TW'(0));
        ready_mode = 1;
        wait_obs();
        cmp_all("t3_drain");
        expect_stripe(0);
        expect_stripe(1);
        frame_start();
        send_beats(128);
        wait_obs();
        cmp_all("t3_clean");
        chk("t3_clean_ovf", TW'(err_ovf), TW'(0));

        // 4: frame restarts mid stripe 0 -> short frame flagged, next frame clean
        frame_start();
        send_beats(40);
        expect_stripe(0);
        expect_stripe(1);
        frame_start();
        send_beats(128);
        chk("t4_short_set", TW'(err_short), TW'(1));
        wait_obs();
        cmp_all("t4");
        pulse_clr();
        chk("t4_short_cleared", TW'(err_short), TW'(0));

        // 5: capture disabled for one frame
        en = 1'b0;
        frame_start();
        send_beats(128);
        repeat (100) tick();
        wait_obs();
        cmp_all("t5_disabled");
        en = 1'b1;
        expect_stripe(0);
        expect_stripe(1);
        frame_start();
        send_beats(128);
        wait_obs();
        cmp_all("t5_enabled");

        // 6: reset while stripe 1 is being read out
        frame_start();
        send_beats(128);
        for (int i = 0; i < 200 && !(bus.blk_valid && bus.blk_y == 1'b1); i++) tick();
        chk("t6_stripe1_reached", TW'(bus.blk_valid && bus.blk_y == 1'b1), TW'(1));
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_rst_valid", TW'(bus.blk_valid), TW'(0));
        chk("t6_rst_beat", obs_beat(), TW'(0));
        chk("t6_rst_state", TW'(read_state), TW'(0));
        tick();
        rst_n = 1'b1;
        obs_q.delete();
        exp_q.delete();
        tick();
        expect_stripe(0);
        expect_stripe(1);
        frame_start();
        send_beats(128);
        wait_obs();
        cmp_all("t6_after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
